// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/half_sub.sv
// Half-subtractor cell: d = x - y, borrow out when x=0 and y=1.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

// File: rtl/serial_sub_full_sub_bit.sv
// Combinational full-subtractor bit: two cascaded half-subtractors, with
// their borrows ORed together.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_sub u_hs0 (
    .x    (x),
    .y    (y),
    .d    (d1),
    .bout (b1)
  );

  half_sub u_hs1 (
    .x    (d1),
    .y    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock,
// with a start/ready/done handshake. The result registers hold until the next finish.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic d_bit;
  logic borrow_nxt;

  full_sub_bit u_bit (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (borrow_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request directly so held start runs back-to-back.
        if (start) begin
          state_d  = SHIFT;
          a_sh_d   = a;
          b_sh_d   = b;
          r_sh_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        r_sh_d   = {d_bit, r_sh_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          diff_d  = {d_bit, r_sh_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q != SHIFT);
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table, multi-cycle
// corner sequences and randomized operands against an arithmetic model.
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks;
  int errors;
  logic [WIDTH-1:0] last_diff;
  logic             last_bout;
  logic             prev_done;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic and an unsigned compare.
  function automatic logic [WIDTH-1:0] model_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int r;
    r = (int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH);
    return WIDTH'(r);
  endfunction

  function automatic logic model_bout(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return int'(x) < int'(y);
  endfunction

  // Counts edges until done, checking results hold while the op is in flight.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (done !== 1'b1) begin
        check("diff_hold", 32'(diff), 32'(last_diff));
        check("bout_hold", 32'(bout), 32'(last_bout));
      end
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic [WIDTH-1:0] ed, input logic eb);
    int n;
    a = xa;
    b = xb;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_load", 32'(busy), 32'd1);
    check("ready_after_load", 32'(ready), 32'd0);
    wait_done(n);
    check("latency", 32'(n), 32'(WIDTH));
    check("diff", 32'(diff), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("ready_in_done", 32'(ready), 32'd1);
    $display("op a=0x%02h b=0x%02h -> diff=0x%02h bout=%0d (exp 0x%02h/%0d) lat=%0d",
             xa, xb, diff, bout, ed, eb, n);
    last_diff = ed;
    last_bout = eb;
    tick();
    check("done_single", 32'(done), 32'd0);
  endtask

  // done must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_consecutive: got 1 expected 0");
      end
    end
    prev_done = done;
  end

  initial begin
    int n;
    int nd;
    logic [WIDTH-1:0] ra, rb;
    checks = 0;
    errors = 0;
    prev_done = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};

    tick();
    tick();
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    last_diff = '0;
    last_bout = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_bout);

    // Back-to-back with start held: second load happens in the DONE cycle.
    a = 8'h80;
    b = 8'h7F;
    start = 1'b1;
    tick();
    a = 8'h10;
    b = 8'h20;
    wait_done(n);
    check("b2b_latency1", 32'(n), 32'(WIDTH));
    check("b2b_diff1", 32'(diff), 32'h01);
    check("b2b_bout1", 32'(bout), 32'd0);
    $display("b2b op1 diff=0x%02h bout=%0d", diff, bout);
    last_diff = 8'h01;
    last_bout = 1'b0;
    tick();
    start = 1'b0;
    check("b2b_reload_busy", 32'(busy), 32'd1);
    wait_done(nd);
    check("b2b_done_spacing", 32'(nd + 1), 32'(WIDTH + 1));
    check("b2b_diff2", 32'(diff), 32'hF0);
    check("b2b_bout2", 32'(bout), 32'd1);
    $display("b2b op2 diff=0x%02h bout=%0d spacing=%0d", diff, bout, nd + 1);
    last_diff = 8'hF0;
    last_bout = 1'b1;
    tick();
    check("b2b_idle", 32'(ready), 32'd1);

    // start and operand changes during SHIFT are ignored.
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("ign_latency", 32'(n + 3), 32'(WIDTH));
    check("ign_diff", 32'(diff), 32'h05);
    check("ign_bout", 32'(bout), 32'd0);
    $display("ignore op diff=0x%02h bout=%0d", diff, bout);
    last_diff = 8'h05;
    last_bout = 1'b0;
    tick();
    check("ign_no_requeue", 32'(busy), 32'd0);

    // Reset in flight aborts the op with no done.
    a = 8'h44;
    b = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n++;
      tick();
    end
    check("abort_no_done", 32'(n), 32'd0);
    $display("abort: diff=0x%02h bout=%0d ready=%0d stray_done=%0d", diff, bout, ready, n);
    last_diff = '0;
    last_bout = 1'b0;
    run_op(8'h20, 8'h01, 8'h1F, 1'b0);

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i == 0) begin
        ra = 8'hFF;
        rb = 8'hFF;
      end
      run_op(ra, rb, model_diff(ra, rb), model_bout(ra, rb));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
